// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the burst scratch memory.
// Holds the controller state encoding, direction codes and strobe-width helpers.
package burst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic DIR_WR = 1'b1;
    localparam logic DIR_RD = 1'b0;

    localparam int DEF_WIDTH  = 32;
    localparam int STRB_WIDTH = DEF_WIDTH / 8;

    function automatic bit width_ok(input int w);
        return (w % 8) == 0;
    endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Current word address and beat counter for one burst.
// The address wraps from DEPTH-1 to 0, so DEPTH need not be a power of two.
module burst_addr_gen #(
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int LEN_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] cur,
    output logic [ADDR_WIDTH-1:0] next_cur,
    output logic                  last
);

    logic [LEN_WIDTH-1:0] cnt;
    logic [LEN_WIDTH-1:0] len_q;

    assign next_cur = (cur == ADDR_WIDTH'(DEPTH - 1)) ? '0 : cur + 1'b1;
    assign last     = (cnt == len_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur   <= '0;
            cnt   <= '0;
            len_q <= '0;
        end else if (load) begin
            cur   <= start;
            cnt   <= '0;
            len_q <= len;
        end else if (advance) begin
            cur   <= next_cur;
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/burst_mem.sv
// Single-port scratch memory serving multi-beat read/write bursts with
// valid/ready beats, byte strobes, address wrap and a done/err completion pulse.
module burst_mem
    import burst_mem_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int MAX_LEN    = 8,
    parameter int LEN_WIDTH  = $clog2(MAX_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  ready,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    output logic                  rlast,
    input  logic                  rready,
    output logic                  done,
    output logic                  err
);

    localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("burst_mem: WIDTH must be a multiple of 8");
    end

    state_t                  state, next_state;
    logic                    err_q;
    logic [ADDR_WIDTH-1:0]   cur, next_cur;
    logic                    last;
    logic                    accept, wbeat, rbeat, addr_bad;
    logic [WIDTH-1:0]        mem [DEPTH];

    assign accept   = valid && ready;
    assign wbeat    = wvalid && wready;
    assign rbeat    = rvalid && rready;
    assign addr_bad = 32'(addr) >= DEPTH;
    assign rlast    = rvalid && last;

    burst_addr_gen #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .start    (addr),
        .len      (len),
        .advance  (wbeat || rbeat),
        .cur      (cur),
        .next_cur (next_cur),
        .last     (last)
    );

    // NOTE: next_state gets a default before any branch so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (addr_bad)              next_state = RESP;
                    else if (wr_rd == DIR_WR)  next_state = WRITE;
                    else                       next_state = READ;
                end
            end
            WRITE:   if (wbeat && last) next_state = RESP;
            READ:    if (rbeat && last) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs are registered decodes of the upcoming state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ready  <= 1'b0;
            wready <= 1'b0;
            rvalid <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= next_state;
            ready  <= (next_state == IDLE);
            wready <= (next_state == WRITE);
            rvalid <= (next_state == READ);
            done   <= (state == RESP);
            err    <= (state == RESP) && err_q;
            if (accept) err_q <= addr_bad;
        end
    end

    // NOTE: the array is cleared by reset, so it maps to flops rather than a
    // RAM macro; that is what makes every word read back as zero after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wbeat) begin
            for (int k = 0; k < WIDTH / 8; k++) begin
                if (wstrb[k]) mem[cur[IDX_WIDTH-1:0]][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    // Prefetch the next word on each accepted beat for one beat per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (accept && !addr_bad && wr_rd == DIR_RD) begin
            rdata <= mem[addr[IDX_WIDTH-1:0]];
        end else if (rbeat && !last) begin
            rdata <= mem[next_cur[IDX_WIDTH-1:0]];
        end
    end

endmodule

// File: tb/tb_burst_mem.sv
// Self-checking bench for burst_mem: directed scenarios plus randomized bursts
// compared against a word-array reference model with modulo-DEPTH addressing.
module tb_burst_mem;
    import burst_mem_pkg::*;

    localparam int WIDTH = DEF_WIDTH;
    localparam int DEPTH = 32;
    localparam int AW    = 6;
    localparam int LW    = 3;

    logic                  clk;
    logic                  rst;
    logic                  valid;
    logic                  wr_rd;
    logic [AW-1:0]         addr;
    logic [LW-1:0]         len;
    logic                  ready;
    logic [WIDTH-1:0]      wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [WIDTH-1:0]      rdata;
    logic                  rvalid;
    logic                  rlast;
    logic                  rready;
    logic                  done;
    logic                  err;

    burst_mem #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .MAX_LEN(8), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst), .valid(valid), .wr_rd(wr_rd), .addr(addr), .len(len),
        .ready(ready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0]      model [DEPTH];
    logic [WIDTH-1:0]      wd [$];
    logic [STRB_WIDTH-1:0] ws [$];
    bit                    rpat [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic request(input bit dir, input int a, input int l, output bit ok);
        int n;
        valid = 1'b1;
        wr_rd = dir;
        addr  = AW'(a);
        len   = LW'(l);
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL req_ready addr=%0d got=%b want=1", a, ready);
            valid = 1'b0;
            ok = 1'b0;
            return;
        end
        step();
        valid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic expect_done(input bit exp_err, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        total++;
        if (done !== 1'b1 || err !== exp_err) begin
            bad++;
            $display("FAIL %s_done got done=%b err=%b want done=1 err=%b", tag, done, err, exp_err);
        end
        step();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s_done_pulse got done=%b want=0", tag, done);
        end
    endtask

    // Writes wd/ws starting at a; stall=1 randomly drops wvalid.
    task automatic write_burst(input int a, input int l, input bit stall);
        bit ok, hs;
        int i, n, idx;
        request(DIR_WR, a, l, ok);
        if (!ok) return;
        i = 0;
        n = 0;
        while (i <= l && n < 60) begin
            total++;
            if (wready !== 1'b1) begin
                bad++;
                $display("FAIL wr_wready beat=%0d got=%b want=1", i, wready);
            end
            if (stall && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
            end else begin
                wvalid = 1'b1;
                wdata  = wd[i];
                wstrb  = ws[i];
            end
            hs = wvalid && wready;
            step();
            n++;
            if (hs) begin
                idx = (a + i) % DEPTH;
                for (int k = 0; k < STRB_WIDTH; k++)
                    if (ws[i][k]) model[idx][8*k +: 8] = wd[i][8*k +: 8];
                i++;
            end
        end
        wvalid = 1'b0;
        total++;
        if (i <= l) begin
            bad++;
            $display("FAIL wr_timeout addr=%0d beats=%0d want=%0d", a, i, l + 1);
        end
        expect_done(1'b0, "wr");
    endtask

    // rpat entries drive rready first; afterwards rand_rdy picks random or constant 1.
    task automatic read_burst(input int a, input int l, input bit rand_rdy);
        bit ok, hs, rr;
        int i, n;
        logic [WIDTH-1:0] exp;
        request(DIR_RD, a, l, ok);
        if (!ok) return;
        i = 0;
        n = 0;
        while (i <= l && n < 200) begin
            exp = model[(a + i) % DEPTH];
            total++;
            if (rvalid !== 1'b1 || rdata !== exp || rlast !== (i == l)) begin
                bad++;
                $display("FAIL rd_beat addr=%0d beat=%0d got rvalid=%b rdata=%h rlast=%b want rvalid=1 rdata=%h rlast=%b",
                         a, i, rvalid, rdata, rlast, exp, (i == l));
            end
            if (rpat.size() > 0)  rr = rpat.pop_front();
            else if (rand_rdy)    rr = ($urandom_range(0, 2) != 0);
            else                  rr = 1'b1;
            rready = rr;
            hs = rvalid && rr;
            step();
            n++;
            if (hs) i++;
        end
        rready = 1'b0;
        total++;
        if (i <= l || rvalid !== 1'b0) begin
            bad++;
            $display("FAIL rd_end addr=%0d beats=%0d want=%0d rvalid=%b want=0", a, i, l + 1, rvalid);
        end
        expect_done(1'b0, "rd");
    endtask

    task automatic test_reset();
        rst = 1'b0; valid = 1'b0; wr_rd = 1'b0; addr = '0; len = '0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; rready = 1'b0;
        model_clear();
        #2;
        total++;
        if ({ready, wready, rvalid, rlast, done, err} !== 6'b0 || rdata !== '0) begin
            bad++;
            $display("FAIL reset_outputs got rdy/wrdy/rv/rl/done/err=%b rdata=%h want all 0",
                     {ready, wready, rvalid, rlast, done, err}, rdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", ready);
        end
    endtask

    task automatic test_read_after_reset();
        read_burst(4, 3, 1'b0);
    endtask

    task automatic test_write_readback();
        wd = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        ws = '{4'hF, 4'hF, 4'hF, 4'hF};
        write_burst(8, 3, 1'b0);
        read_burst(8, 3, 1'b0);
    endtask

    task automatic test_partial_strobe();
        wd = '{32'hAABBCCDD};
        ws = '{4'hF};
        write_burst(2, 0, 1'b0);
        wd = '{32'h11223344};
        ws = '{4'b0101};
        write_burst(2, 0, 1'b0);
        read_burst(2, 0, 1'b0);
    endtask

    task automatic test_wrap_backpressure();
        wd = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        ws = '{4'hF, 4'hF, 4'hF, 4'hF};
        write_burst(30, 3, 1'b0);
        rpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        read_burst(30, 3, 1'b0);
        read_burst(28, 7, 1'b1);
    endtask

    task automatic test_error();
        bit ok;
        for (int t = 0; t < 2; t++) begin
            request(t == 0 ? DIR_WR : DIR_RD, t == 0 ? 40 : 63, 3, ok);
            total++;
            if (done !== 1'b0 || wready !== 1'b0 || rvalid !== 1'b0) begin
                bad++;
                $display("FAIL err_cycle1 got done=%b wready=%b rvalid=%b want 0/0/0", done, wready, rvalid);
            end
            wvalid = 1'b1;
            wdata  = 32'hDEADBEEF;
            wstrb  = 4'hF;
            step();
            total++;
            if (done !== 1'b1 || err !== 1'b1 || wready !== 1'b0 || rvalid !== 1'b0) begin
                bad++;
                $display("FAIL err_cycle2 got done=%b err=%b wready=%b rvalid=%b want 1/1/0/0",
                         done, err, wready, rvalid);
            end
            wvalid = 1'b0;
            step();
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL err_pulse got done=%b want=0", done);
            end
        end
        read_burst(0, 7, 1'b0);
        read_burst(8, 7, 1'b0);
    endtask

    task automatic test_random();
        bit ok;
        int a, l;
        for (int it = 0; it < 30; it++) begin
            l = $urandom_range(0, 7);
            if ($urandom_range(0, 7) == 0) begin
                a = $urandom_range(DEPTH, 63);
                request($urandom_range(0, 1) == 1, a, l, ok);
                if (ok) expect_done(1'b1, "rand_err");
            end else begin
                a = $urandom_range(0, DEPTH - 1);
                if ($urandom_range(0, 1) == 1) begin
                    wd.delete();
                    ws.delete();
                    for (int i = 0; i <= l; i++) begin
                        wd.push_back($urandom);
                        ws.push_back(STRB_WIDTH'($urandom_range(0, 15)));
                    end
                    write_burst(a, l, 1'b1);
                end else begin
                    read_burst(a, l, 1'b1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        wd = '{32'h5A5A0001, 32'h5A5A0002, 32'h5A5A0003, 32'h5A5A0004};
        request(DIR_WR, 12, 3, ok);
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1;
            wdata  = wd[i];
            wstrb  = 4'hF;
            step();
        end
        wvalid = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (wready !== 1'b0 || rvalid !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_outputs got wready=%b rvalid=%b ready=%b want 0/0/0", wready, rvalid, ready);
        end
        model_clear();
        for (int c = 0; c < 6; c++) begin
            if (c == 3) rst = 1'b1;
            step();
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL midrst_done cycle=%0d got=%b want=0", c, done);
            end
        end
        for (int b = 0; b < DEPTH; b += 8) read_burst(b, 7, 1'b0);
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_write_readback();
        test_partial_strobe();
        test_wrap_backpressure();
        test_error();
        test_random();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/burst_mem.md
Name: burst_mem

Overview:
Single-port synchronous memory that serves multi-beat bursts rather than one word per request. A request phase carries the start address, length and direction. A data phase then moves one beat per cycle with valid/ready backpressure on both write and read data. Adds byte strobes, address wrap, out-of-range error reporting and a completion pulse; it sits behind the bus master as the local scratch store.

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of 8
DEPTH, 32, number of words; need not be a power of two
ADDR_WIDTH, $clog2(DEPTH), address width
MAX_LEN, 8, maximum beats per burst
LEN_WIDTH, $clog2(MAX_LEN), width of len field (encodes beats-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
valid  in  1  request valid
wr_rd  in  1  1 = write burst, 0 = read burst
addr  in  ADDR_WIDTH  start word address
len  in  LEN_WIDTH  beats minus one
ready  out  1  request accepted when valid&ready
wdata  in  WIDTH  write beat data
wstrb  in  WIDTH/8  byte enables for write beat
wvalid  in  1  write beat valid
wready  out  1  write beat accepted when wvalid&wready
rdata  out  WIDTH  read beat data
rvalid  out  1  read beat valid
rlast  out  1  marks final read beat
rready  in  1  consumer accepts read beat
done  out  1  one-cycle completion pulse
err  out  1  qualifies done; 1 = burst rejected

Behaviour:
- Reset (rst=0, async): state IDLE; all memory words, rdata, rvalid, rlast, wready and done/err are cleared to 0; ready=0. A burst in flight is aborted with no done pulse.
- States: IDLE, WRITE, READ, RESP.
- IDLE: ready=1. On valid&ready, latch addr, len and wr_rd, and set beat counter=0.
  - If addr>=DEPTH: go to RESP with err=1; no memory access.
  - Else if wr_rd=1: go to WRITE.
  - Else: go to READ and load rdata=mem[addr], with rvalid=1 the next cycle.
  - Request latency is one cycle.
- WRITE: wready=1.
  - On each wvalid&wready, byte lane k of mem[cur] is updated only where wstrb[k]=1; other lanes keep their value.
  - cur advances and the counter increments.
  - After beat len, go to RESP with err=0.
  - wvalid=0 stalls the burst indefinitely.
- READ: rvalid=1 and rdata=mem[cur]; rlast=1 when counter==len.
  - On rvalid&rready, advance cur and load the next word on the same edge, giving one beat per cycle with rready held high.
  - rready=0 holds rdata, rvalid and rlast stable.
  - After the rlast handshake: rvalid=0, go to RESP with err=0.
- Address wrap: cur+1 when cur==DEPTH-1 becomes 0, not 2^ADDR_WIDTH. A burst may therefore cross the top of memory.
- RESP: done=1 for exactly one cycle with err, then go to IDLE. ready=0 in RESP, so back-to-back requests are spaced by at least one cycle.
- Output gating: wready=0 outside WRITE; rvalid=0 outside READ.
- Read-after-write: the first read beat of a burst accepted after done reflects all strobed bytes of the prior write.
- len=0 is a single-beat burst, and the rlast beat equals the first beat.

Decomposition:
- Package burst_mem_pkg:
  - state enum (IDLE, WRITE, READ, RESP)
  - constants DIR_WR=1 and DIR_RD=0
  - localparam STRB_WIDTH=WIDTH/8
  - a check that WIDTH%8==0
- Sub-module burst_addr_gen:
  - holds cur address and beat counter
  - ports: load, start addr, len, advance
  - outputs: cur, last
  - handles wrap at DEPTH-1

Test Plan:
- Reset then read: burst of len=3 at addr 4 -> 4 beats all 0x00000000, rlast on beat 4, then done=1, err=0.
- Write/read-back: write len=3 at addr 8 with data 0x11111111..0x44444444 and wstrb=0xF -> a read of len=3 at addr 8 returns those four words in order.
- Partial strobe: word 2 = 0xAABBCCDD, then write 0x11223344 with wstrb=0b0101 -> read gives 0xAA22CC44.
- Wrap and backpressure: write 0xA0..0xA3 at addr 30, len=3, DEPTH=32 -> words land in 30, 31, 0, 1. A read of the same burst with rready toggling 1,0,0,1,1,0,1 returns each beat exactly once, with rdata held stable while rready=0.
- Error: request at addr 40 with DEPTH=32 -> done=1 and err=1 two cycles after acceptance; no wready/rvalid; memory unchanged.
- Reset mid-burst: deassert rst after 2 of 4 write beats -> immediately rvalid=wready=0, no done pulse, all words read back as 0 after release.
